gamepad_event_ctrl: RTL
=======================

Name: gamepad_event_ctrl

Overview:
Parametrised successor to the gamepad I/O interface. It synchronises and debounces NUM_INPUTS raw gamepad lines (joystick and buttons) and detects press/release edges. Filtered edges are queued in an event FIFO, and a level IRQ is raised toward the soft processor. It sits between the board pins and the 64-bit PIO command/read pair of the processor system, and also drives the board LEDs.

Parameters:
NUM_INPUTS, 12, number of raw input lines; legal range 1..24.
DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a new level; minimum 1.
FIFO_DEPTH, 8, event FIFO entries; power of two, 2..32.
LED_W, 8, LED output width; legal range 1..32.

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
raw_in  in  NUM_INPUTS  asynchronous raw buttons; 1 = pressed
we  in  1  one-cycle command strobe, already pulse-shaped upstream
writedata  in  64  command word
readdata  out  64  registered status/event word
irq  out  1  level interrupt
leds  out  LED_W  LED register

Behaviour:
- Reset (rst_n=0 at a clk edge) clears the following:
  - Synchroniser flops, debounce counters, stable state and FIFO pointers: cleared; count=0.
  - overflow flag: 0; readdata: 0; irq: 0; leds: 0.
  - Filter masks: press_en = all ones, release_en = all ones; irq_en = 0.
  - A reset mid-event discards all queued events.
- Input path, per line:
  - 2-flop synchroniser feeds a debounce stage.
  - Debounce counter resets whenever the synced value equals the stable value.
  - Otherwise the counter increments; when it reaches DEBOUNCE_CYCLES-1, stable takes the synced value on the next edge and the counter clears.
  - Total latency from a raw change to the stable change = DEBOUNCE_CYCLES+2 cycles.
- Edge detect:
  - changed = stable_new XOR stable_old.
  - Filtered mask = (changed & stable_new & press_en) | (changed & ~stable_new & release_en).
  - A nonzero filtered mask produces exactly one event per cycle: {mask, stable_new}. Simultaneous edges on several lines merge into one event.
- FIFO:
  - Entry = 24-bit mask + 24-bit state snapshot; bits above NUM_INPUTS are zero.
  - Push when full: the event is dropped and overflow is set (sticky).
  - Pop when empty: ignored, no error.
  - Push and pop in the same cycle: both happen and count is unchanged. This includes the full case, where the push is accepted.
- Commands, applied on we=1; opcode = writedata[63:56]:
  - 0x01: leds <= writedata[LED_W-1:0].
  - 0x02: press_en <= writedata[23:0], release_en <= writedata[55:32], irq_en <= writedata[24].
  - 0x03: pop the FIFO head.
  - 0x04: clear overflow. If an overflowing push occurs in the same cycle, set wins.
  - 0x05: flush the FIFO (count=0). A same-cycle push is discarded and does not set overflow.
  - Any other opcode: no effect.
  - If we is held high, the command executes every cycle.
- readdata, registered and updated every cycle (1-cycle latency from any state change):
  - [63] = FIFO non-empty
  - [62] = overflow
  - [61:56] = count
  - [55:32] = head mask
  - [31:24] = 0
  - [23:0] = head state snapshot
  - Head fields read 0 when the FIFO is empty.
- irq: registered; irq = irq_en AND (count != 0), with 1-cycle latency. It deasserts the cycle after the pop that empties the FIFO.

Test Plan:
1. Run with NUM_INPUTS=12, DEBOUNCE_CYCLES=4, FIFO_DEPTH=4. After reset: readdata=0, leds=0, irq=0. Then we with writedata=0x0100_0000_0000_00A5 -> leds=0xA5 next cycle.
2. Hold raw_in[3]=1 for 3 cycles, then drop it -> no event. Hold it for ≥6 cycles -> exactly one event; readdata[55:32]=0x000008, [23:0]=0x000008, [63]=1, count=1.
3. Send opcode 0x02 with irq_en=1, release_en=0. Press then release line 0 -> only the press event is queued. irq=1. Pop (opcode 0x03) -> count=0, and irq=0 one cycle after the pop.
4. Generate 5 distinct press events with no pops -> count=4, overflow=1, and the head is the first event. Opcode 0x04 -> overflow=0 while count stays 4.
5. Raise raw_in[1] and raw_in[5] in the same cycle -> a single event with mask 0x000022. With the FIFO full, a push and pop in the same cycle -> count stays 4 and overflow stays 0.
6. Flush (0x05) in the same cycle as a new push -> count=0 and overflow=0. Then assert reset with 2 events queued -> all state returns to reset values.

Source files
------------

// File: rtl/gamepad_event_ctrl.sv
// gamepad_event_ctrl: debounced gamepad inputs, press/release event FIFO, IRQ and LED register
module gamepad_event_ctrl #(
  parameter int NUM_INPUTS      = 12,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int FIFO_DEPTH      = 8,
  parameter int LED_W           = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_INPUTS-1:0] raw_in,
  input  logic                  we,
  input  logic [63:0]           writedata,
  output logic [63:0]           readdata,
  output logic                  irq,
  output logic [LED_W-1:0]      leds
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
  logic [NUM_INPUTS-1:0] s1, s2, stable, stable_nxt, hit, filt;
  logic [CW-1:0] cnt [NUM_INPUTS];
  logic [23:0] press_en, release_en;
  logic irq_en, ovf, full, pop, push_req, push, ovf_set;
  logic cmd_led, cmd_cfg, cmd_pop, cmd_clr, cmd_flush;
  logic [47:0] mem [FIFO_DEPTH];
  logic [47:0] ev, head;
  logic [AW-1:0] wp, rp;
  logic [AW:0] count;
  logic unused;
  assign unused = ^{writedata, press_en, release_en};
  always_ff @(posedge clk) begin
    s1 <= rst_n ? raw_in : '0;
    s2 <= rst_n ? s1 : '0;
    stable <= rst_n ? stable_nxt : '0;
  end
  // hit fires after DEBOUNCE_CYCLES consecutive samples disagreeing with stable
  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_db
    assign hit[i] = (s2[i] != stable[i]) && (cnt[i] == CMAX);
    always_ff @(posedge clk)
      if (!rst_n || s2[i] == stable[i] || hit[i]) cnt[i] <= '0;
      else cnt[i] <= cnt[i] + 1'b1;
  end
  assign stable_nxt = stable ^ hit;
  assign filt = hit & ((stable_nxt & press_en[NUM_INPUTS-1:0]) | (~stable_nxt & release_en[NUM_INPUTS-1:0]));
  assign ev = {24'(filt), 24'(stable_nxt)};
  assign cmd_led   = we && writedata[63:56] == 8'h01;
  assign cmd_cfg   = we && writedata[63:56] == 8'h02;
  assign cmd_pop   = we && writedata[63:56] == 8'h03;
  assign cmd_clr   = we && writedata[63:56] == 8'h04;
  assign cmd_flush = we && writedata[63:56] == 8'h05;
  assign full     = count == FULL;
  assign pop      = cmd_pop && count != '0;
  assign push_req = |filt && !cmd_flush;
  assign push     = push_req && (!full || pop);
  assign ovf_set  = push_req && full && !pop;
  assign head     = count != '0 ? mem[rp] : '0;
  always_ff @(posedge clk)
    if (push) mem[wp] <= ev;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      ovf <= 1'b0;
      press_en <= '1;
      release_en <= '1;
      irq_en <= 1'b0;
      leds <= '0;
      readdata <= '0;
      irq <= 1'b0;
    end else begin
      if (cmd_flush) begin
        wp <= '0;
        rp <= '0;
        count <= '0;
      end else begin
        wp <= wp + AW'(push);
        rp <= rp + AW'(pop);
        count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
      ovf <= ovf_set | (ovf & ~cmd_clr);
      if (cmd_led) leds <= writedata[LED_W-1:0];
      if (cmd_cfg) begin
        press_en <= writedata[23:0];
        release_en <= writedata[55:32];
        irq_en <= writedata[24];
      end
      readdata <= {count != '0, ovf, 6'(count), head[47:24], 8'h00, head[23:0]};
      irq <= irq_en && count != '0;
    end
  end
endmodule
